// File: rtl/matrix_mac_pkg.sv
// Shared types and constants for the 4x4 matrix MAC datapath and its operand loader.
package matrix_mac_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int MAT_DIM    = 4;
  localparam int TILE_BEATS = 32;

  typedef logic [DATA_WIDTH-1:0] elem_t;
  typedef elem_t [0:MAT_DIM-1][0:MAT_DIM-1] mat_t;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } ldr_state_t;

endpackage

// File: rtl/matrix_tile_loader.sv
// Assembles a serial element stream into parallel 4x4 A/B operand tiles for the MAC.
// Define TRANSPOSE_B_EN when the B operand arrives column-major in the stream.
module matrix_tile_loader #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [DATA_WIDTH-1:0]               s_data,
  input  logic                                s_last,
  output logic                                tile_valid,
  input  logic                                tile_ready,
  output logic                                tile_first,
  output logic [0:3][0:3][DATA_WIDTH-1:0]     mat_a,
  output logic [0:3][0:3][DATA_WIDTH-1:0]     mat_b,
  output logic                                err_framing
);
  import matrix_mac_pkg::*;

  localparam logic [4:0] A_LAST_BEAT = 5'(TILE_BEATS / 2 - 1);
  localparam logic [4:0] B_LAST_BEAT = 5'(TILE_BEATS - 1);

  ldr_state_t state;
  logic [4:0] idx;
  logic       grp_open;
  logic       beat_accept;

  // Both handshake outputs decode straight from the state register, so
  // tile_ready never reaches s_ready combinationally.
  assign s_ready     = (state != HOLD);
  assign tile_valid  = (state == HOLD);
  assign beat_accept = s_valid && s_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= LOAD_A;
      idx         <= '0;
      grp_open    <= 1'b1;
      tile_first  <= 1'b0;
      err_framing <= 1'b0;
      mat_a       <= '0;
      mat_b       <= '0;
    end else begin
      case (state)
        LOAD_A, LOAD_B: begin
          if (beat_accept) begin
            if (!idx[4]) begin
              mat_a[idx[3:2]][idx[1:0]] <= s_data;
            end else begin
`ifdef TRANSPOSE_B_EN
              mat_b[idx[1:0]][idx[3:2]] <= s_data;
`else
              mat_b[idx[3:2]][idx[1:0]] <= s_data;
`endif
            end
            if (s_last && (idx != B_LAST_BEAT)) begin
              err_framing <= 1'b1;
            end
            if (idx == A_LAST_BEAT) begin
              state <= LOAD_B;
            end
            // Closing beat: publish the tile and decide whether the next one opens a group.
            if (idx == B_LAST_BEAT) begin
              state      <= HOLD;
              tile_first <= grp_open;
              grp_open   <= s_last;
            end
            idx <= idx + 5'd1;
          end
        end
        HOLD: begin
          if (tile_ready) begin
            state <= LOAD_A;
          end
        end
        default: begin
          state <= LOAD_A;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_tile_loader.sv
// Scoreboard bench for matrix_tile_loader: expected tiles are queued as beats are driven.
module tb_matrix_tile_loader;

  localparam int DW = 8;

  typedef logic [0:3][0:3][DW-1:0] tile_t;
  typedef struct {
    tile_t a;
    tile_t b;
    logic  first;
  } exp_tile_t;

  logic          clock;
  logic          reset;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          tile_valid;
  logic          tile_ready;
  logic          tile_first;
  tile_t         mat_a;
  tile_t         mat_b;
  logic          err_framing;

  int checks   = 0;
  int failures = 0;

  exp_tile_t expQ[$];
  tile_t     mdlA;
  tile_t     mdlB;
  int        mdlIdx;
  logic      mdlGrpOpen;
  logic      mdlErr;

  matrix_tile_loader #(.DATA_WIDTH(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .tile_valid  (tile_valid),
    .tile_ready  (tile_ready),
    .tile_first  (tile_first),
    .mat_a       (mat_a),
    .mat_b       (mat_b),
    .err_framing (err_framing)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mdlA       = '0;
    mdlB       = '0;
    mdlIdx     = 0;
    mdlGrpOpen = 1'b1;
    mdlErr     = 1'b0;
  endtask

  // Drives one beat (waiting for s_ready) and advances the reference model.
  task automatic applyStimulus(input logic [DW-1:0] d, input logic last);
    int budget;
    int k;
    exp_tile_t e;
    budget = 0;
    while (!s_ready && budget < 100) begin
      @(negedge clock);
      budget++;
    end
    checkOutput("s_ready_wait", {127'd0, s_ready}, 128'd1);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge clock);
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (mdlIdx < 16) begin
      mdlA[mdlIdx / 4][mdlIdx % 4] = d;
    end else begin
      k = mdlIdx - 16;
`ifdef TRANSPOSE_B_EN
      mdlB[k % 4][k / 4] = d;
`else
      mdlB[k / 4][k % 4] = d;
`endif
    end
    if (last && mdlIdx != 31) mdlErr = 1'b1;
    if (mdlIdx == 31) begin
      e.a = mdlA;
      e.b = mdlB;
      e.first = mdlGrpOpen;
      expQ.push_back(e);
      mdlGrpOpen = last;
      mdlIdx = 0;
    end else begin
      mdlIdx++;
    end
    checkOutput("err_framing", {127'd0, err_framing}, {127'd0, mdlErr});
  endtask

  task automatic sendBeats(input int n, input int startVal, input int lastBeat, input bit randData);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = randData ? DW'($urandom_range(0, 255)) : DW'(startVal + i);
      applyStimulus(d, (i == lastBeat));
    end
  endtask

  // Waits for a presented tile, compares it to the queue head, optionally stalls, then accepts it.
  task automatic consumeTile(input int stall);
    int budget;
    exp_tile_t e;
    tile_t heldA;
    tile_t heldB;
    budget = 0;
    while (!tile_valid && budget < 100) begin
      @(negedge clock);
      budget++;
    end
    checkOutput("tile_valid_wait", {127'd0, tile_valid}, 128'd1);
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_empty", 128'd0, 128'd1);
      return;
    end
    e = expQ.pop_front();
    checkOutput("mat_a", mat_a, e.a);
    checkOutput("mat_b", mat_b, e.b);
    checkOutput("tile_first", {127'd0, tile_first}, {127'd0, e.first});
    heldA = mat_a;
    heldB = mat_b;
    if (stall > 0) begin
      tile_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        @(negedge clock);
        checkOutput("stall_s_ready", {127'd0, s_ready}, 128'd0);
        checkOutput("stall_tile_valid", {127'd0, tile_valid}, 128'd1);
        checkOutput("stall_mat_a", mat_a, heldA);
        checkOutput("stall_mat_b", mat_b, heldB);
        checkOutput("stall_first", {127'd0, tile_first}, {127'd0, e.first});
      end
      tile_ready = 1'b1;
    end
    @(negedge clock);
    checkOutput("tile_valid_pulse", {127'd0, tile_valid}, 128'd0);
    checkOutput("s_ready_return", {127'd0, s_ready}, 128'd1);
  endtask

  task automatic doReset();
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    modelReset();
    @(negedge clock);
    checkOutput("rst_s_ready", {127'd0, s_ready}, 128'd1);
    checkOutput("rst_tile_valid", {127'd0, tile_valid}, 128'd0);
    checkOutput("rst_tile_first", {127'd0, tile_first}, 128'd0);
    checkOutput("rst_err", {127'd0, err_framing}, 128'd0);
    checkOutput("rst_mat_a", mat_a, 128'd0);
    checkOutput("rst_mat_b", mat_b, 128'd0);
  endtask

  initial begin
    reset      = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    s_last     = 1'b0;
    tile_ready = 1'b1;
    modelReset();
    @(negedge clock);
    doReset();

    $display("[TB] step 1: values 1..32 with s_last on beat 31");
    sendBeats(32, 1, 31, 1'b0);
    checkOutput("a00", {120'd0, mat_a[0][0]}, 128'd1);
    checkOutput("a33", {120'd0, mat_a[3][3]}, 128'd16);
    checkOutput("b33", {120'd0, mat_b[3][3]}, 128'd32);
`ifdef TRANSPOSE_B_EN
    checkOutput("b10_t", {120'd0, mat_b[1][0]}, 128'd18);
    checkOutput("b03_t", {120'd0, mat_b[0][3]}, 128'd29);
`else
    checkOutput("b01", {120'd0, mat_b[0][1]}, 128'd18);
`endif
    checkOutput("t1_first", {127'd0, tile_first}, 128'd1);
    consumeTile(0);

    $display("[TB] step 2: group tracking across tiles");
    sendBeats(32, 40, -1, 1'b0);
    consumeTile(0);
    sendBeats(32, 80, 31, 1'b0);
    consumeTile(0);
    sendBeats(32, 120, -1, 1'b1);
    consumeTile(0);

    $display("[TB] step 3: downstream stall");
    sendBeats(32, 160, -1, 1'b1);
    consumeTile(10);
    sendBeats(32, 200, -1, 1'b0);
    consumeTile(0);

    $display("[TB] step 4: framing error on beat 5");
    sendBeats(32, 3, 5, 1'b0);
    consumeTile(0);
    sendBeats(32, 50, 31, 1'b1);
    consumeTile(0);
    checkOutput("err_sticky", {127'd0, err_framing}, 128'd1);

    $display("[TB] step 5: reset mid-load");
    sendBeats(20, 90, -1, 1'b0);
    doReset();
    sendBeats(32, 1, -1, 1'b1);
    consumeTile(0);

    checkOutput("queue_drained", 128'(expQ.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
